// File: rtl/counter4_run_ctrl.sv
// -----------------------------------------------------------------------------
// counter4_run_ctrl
//
// Run controller for the 4-bit enable counter. Accepts CLEAR / RUN commands
// over a valid/ready handshake and turns them into paced single-cycle
// cnt_en / cnt_rst strobes. It also tracks the value the counter should hold
// and checks the counter's feedback in a dedicated SETTLE cycle at the end
// of every command.
//
// Optional feature macro: RUN_CHECK_EN
//   defined   : SETTLE compares cnt_val against exp_val and sets sticky err.
//   undefined : cnt_val is ignored and err is tied low. SETTLE still takes
//               one cycle, so command timing does not change.
//
// Ports:
//   GCLK_Pad   in   clock, rising edge
//   rst_Pad    in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE only)
//   cmd_op     in   0 = CLEAR, 1 = RUN
//   cmd_len    in   RUN: number of enable strobes
//   cmd_gap    in   RUN: idle cycles between consecutive strobes
//   abort      in   stop an in-progress RUN
//   cnt_en     out  enable strobe to the counter
//   cnt_rst    out  clear strobe to the counter
//   cnt_val    in   counter value feedback
//   exp_val    out  expected counter value
//   busy       out  state is not IDLE
//   done       out  one-cycle completion pulse
//   aborted    out  last RUN was ended by abort (sticky until next command)
//   err        out  feedback mismatch (sticky until CLEAR or reset)
// -----------------------------------------------------------------------------
module counter4_run_ctrl #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic             cnt_en,
    output logic             cnt_rst,
    input  logic [CNT_W-1:0] cnt_val,
    output logic [CNT_W-1:0] exp_val,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN_EN,
        ST_RUN_GAP,
        ST_SETTLE,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] left_q;      // strobes still to issue, including the current one
    logic [GAP_W-1:0] gap_q;       // latched gap length
    logic [GAP_W-1:0] gap_cnt_q;   // gap cycles remaining in RUN_GAP
    logic [CNT_W-1:0] exp_q;
    logic             err_q;
    logic             aborted_q;
    logic             cmd_ready_q;
    logic             cnt_en_q;
    logic             cnt_rst_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             chk_fail;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef RUN_CHECK_EN
    // Counter feedback is registered, so in SETTLE it reflects every strobe
    // issued up to and including the last RUN_EN / CLR cycle.
    assign chk_fail = (state_q == ST_SETTLE) && (cnt_val != exp_q);
`else
    logic unused_cnt_val;
    assign unused_cnt_val = ^cnt_val;
    assign chk_fail       = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cmd_op)                state_d = ST_CLR;
                    else if (cmd_len == '0)     state_d = ST_SETTLE;
                    else                        state_d = ST_RUN_EN;
                end
            end
            ST_CLR:     state_d = ST_SETTLE;
            ST_RUN_EN: begin
                // The last strobe goes straight to SETTLE: no trailing gap.
                if (abort || left_q == CNT_W'(1)) state_d = ST_SETTLE;
                else if (gap_q == '0)             state_d = ST_RUN_EN;
                else                              state_d = ST_RUN_GAP;
            end
            ST_RUN_GAP: begin
                if (abort)                          state_d = ST_SETTLE;
                else if (gap_cnt_q == GAP_W'(1))    state_d = ST_RUN_EN;
            end
            ST_SETTLE:  state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            state_q     <= ST_IDLE;
            left_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            cnt_en_q    <= 1'b0;
            cnt_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;

            // Outputs are registered decodes of the next state, so they are
            // glitch-free and aligned with the state they describe.
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            cnt_en_q    <= (state_d == ST_RUN_EN);
            cnt_rst_q   <= (state_d == ST_CLR);
            done_q      <= (state_d == ST_DONE);

            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        left_q    <= cmd_len;
                        gap_q     <= cmd_gap;
                        aborted_q <= 1'b0;
                    end
                end
                ST_CLR: begin
                    exp_q <= '0;
                    err_q <= 1'b0;
                end
                ST_RUN_EN: begin
                    // The counter samples this strobe on the same edge.
                    exp_q     <= exp_q + CNT_W'(1);
                    left_q    <= left_q - CNT_W'(1);
                    gap_cnt_q <= gap_q;
                    if (abort) aborted_q <= 1'b1;
                end
                ST_RUN_GAP: begin
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    if (abort) aborted_q <= 1'b1;
                end
                ST_SETTLE: begin
                    if (chk_fail) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_rst   = cnt_rst_q;
    assign exp_val   = exp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter4_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter4_run_ctrl
//
// Self-checking bench for counter4_run_ctrl. A small counter model closes the
// cnt_en / cnt_rst -> cnt_val loop. Each command in the vector table has its
// per-cycle strobe / done / busy / ready schedule derived from the command
// timing formulas and pushed to a scoreboard queue, which is popped and
// compared cycle by cycle. End-of-command state (exp_val, aborted, err) comes
// from the table. A hand-written sequence covers reset in the middle of a RUN.
// -----------------------------------------------------------------------------
module tb_counter4_run_ctrl;

`ifdef RUN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       GCLK_Pad = 1'b0;
    logic       rst_Pad  = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [3:0] cmd_len = '0;
    logic [3:0] cmd_gap = '0;
    logic       abort = 1'b0;
    logic       cnt_en;
    logic       cnt_rst;
    logic [3:0] cnt_val;
    logic [3:0] exp_val;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;

    counter4_run_ctrl dut (
        .GCLK_Pad  (GCLK_Pad),
        .rst_Pad   (rst_Pad),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .abort     (abort),
        .cnt_en    (cnt_en),
        .cnt_rst   (cnt_rst),
        .cnt_val   (cnt_val),
        .exp_val   (exp_val),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err)
    );

    always #5 GCLK_Pad = ~GCLK_Pad;

    // Counter model: registered, clear has priority over enable.
    logic [3:0] cnt_q = '0;
    bit         stuck = 1'b0;
    always @(posedge GCLK_Pad) begin
        if (rst_Pad || cnt_rst) cnt_q <= '0;
        else if (cnt_en)        cnt_q <= cnt_q + 4'd1;
    end
    assign cnt_val = stuck ? 4'd0 : cnt_q;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    typedef struct {
        logic       op;
        logic [3:0] len;
        logic [3:0] gap;
        int         abort_k;   // RUN: abort during strobe k; other cmds: abort held in cycle 1
        bit         stuck;
        logic [3:0] exp_cnt;
        bit         exp_ab;
        bit         exp_err;
    } vec_t;

    typedef struct {
        int   cyc;
        logic en;
        logic rst;
        logic dn;
        logic bsy;
        logic rdy;
    } exp_cyc_t;

    localparam int NV = 12;
    vec_t     vecs [NV];
    exp_cyc_t sb [$];

    task automatic run_vec(input int vi);
        vec_t     v;
        exp_cyc_t e;
        int       n, last, endc, abort_c, wait_c;
        v = vecs[vi];

        wait_c = 0;
        while (!cmd_ready && wait_c < 50) begin
            @(negedge GCLK_Pad);
            wait_c++;
        end
        if (!cmd_ready) begin
            check($sformatf("v%0d ready_timeout", vi), 32'(cmd_ready), 32'd1);
            return;
        end

        stuck     = v.stuck;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_gap   = v.gap;

        // Expected schedule, relative to accept cycle t.
        abort_c = 0;
        if (!v.op) begin
            endc = 4;
            if (v.abort_k != 0) abort_c = 1;
            for (int c = 1; c <= endc; c++)
                sb.push_back('{c, 1'b0, c == 1, c == 3, c <= 3, c == 4});
        end else if (v.len == 0) begin
            endc = 3;
            if (v.abort_k != 0) abort_c = 1;
            for (int c = 1; c <= endc; c++)
                sb.push_back('{c, 1'b0, 1'b0, c == 2, c <= 2, c == 3});
        end else begin
            n = int'(v.len);
            if (v.abort_k != 0 && v.abort_k < n) n = v.abort_k;
            last = 1 + (n - 1) * (int'(v.gap) + 1);
            endc = last + 3;
            if (v.abort_k != 0) abort_c = last;
            for (int c = 1; c <= endc; c++)
                sb.push_back('{c, (c <= last) && ((c - 1) % (int'(v.gap) + 1) == 0),
                               1'b0, c == last + 2, c <= last + 2, c == last + 3});
        end

        @(negedge GCLK_Pad);
        // Scramble command inputs: they must have been latched at accept.
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_len   = 4'($urandom);
        cmd_gap   = 4'($urandom);

        for (int c = 1; c <= endc; c++) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d sb_underflow", vi), 32'd0, 32'd1);
                break;
            end
            e = sb.pop_front();
            check($sformatf("v%0d c%0d cnt_en",    vi, e.cyc), 32'(cnt_en),    32'(e.en));
            check($sformatf("v%0d c%0d cnt_rst",   vi, e.cyc), 32'(cnt_rst),   32'(e.rst));
            check($sformatf("v%0d c%0d done",      vi, e.cyc), 32'(done),      32'(e.dn));
            check($sformatf("v%0d c%0d busy",      vi, e.cyc), 32'(busy),      32'(e.bsy));
            check($sformatf("v%0d c%0d cmd_ready", vi, e.cyc), 32'(cmd_ready), 32'(e.rdy));
            abort = (c == abort_c);
            @(negedge GCLK_Pad);
        end
        abort = 1'b0;
        sb.delete();

        check($sformatf("v%0d exp_val", vi), 32'(exp_val), 32'(v.exp_cnt));
        check($sformatf("v%0d aborted", vi), 32'(aborted), 32'(v.exp_ab));
        check($sformatf("v%0d err",     vi), 32'(err),     32'(v.exp_err));
        stuck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op   len    gap   abk stk  exp    ab    err
        vecs[0]  = '{1'b0, 4'd0,  4'd0,  1, 1'b0, 4'd0,  1'b0, 1'b0};  // CLEAR, abort ignored
        vecs[1]  = '{1'b1, 4'd5,  4'd0,  0, 1'b0, 4'd5,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd7,  4'd0,  0, 1'b0, 4'd12, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd7,  4'd2,  0, 1'b0, 4'd3,  1'b0, 1'b0};  // wraps 15->0
        vecs[4]  = '{1'b1, 4'd10, 4'd1,  4, 1'b0, 4'd7,  1'b1, 1'b0};  // abort on strobe 4
        vecs[5]  = '{1'b1, 4'd0,  4'd0,  1, 1'b0, 4'd7,  1'b0, 1'b0};  // len 0, abort ignored
        vecs[6]  = '{1'b1, 4'd15, 4'd0,  0, 1'b0, 4'd6,  1'b0, 1'b0};  // max len
        vecs[7]  = '{1'b1, 4'd1,  4'd15, 0, 1'b0, 4'd7,  1'b0, 1'b0};  // no trailing gap
        vecs[8]  = '{1'b1, 4'd3,  4'd3,  1, 1'b0, 4'd8,  1'b1, 1'b0};  // abort on first strobe
        vecs[9]  = '{1'b1, 4'd3,  4'd0,  0, 1'b1, 4'd11, 1'b0, CHK};   // stuck feedback
        vecs[10] = '{1'b1, 4'd2,  4'd1,  0, 1'b0, 4'd13, 1'b0, CHK};   // err stays sticky
        vecs[11] = '{1'b0, 4'd0,  4'd0,  0, 1'b0, 4'd0,  1'b0, 1'b0};  // CLEAR clears err

        repeat (2) @(negedge GCLK_Pad);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy",      32'(busy),      32'd0);
        check("reset cnt_en",    32'(cnt_en),    32'd0);
        check("reset cnt_rst",   32'(cnt_rst),   32'd0);
        check("reset done",      32'(done),      32'd0);
        check("reset exp_val",   32'(exp_val),   32'd0);
        check("reset aborted",   32'(aborted),   32'd0);
        check("reset err",       32'(err),       32'd0);
        rst_Pad = 1'b0;
        @(negedge GCLK_Pad);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset in the middle of a RUN (len 8, gap 1).
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_len   = 4'd8;
        cmd_gap   = 4'd1;
        @(negedge GCLK_Pad);                 // t+1: strobe 1
        cmd_valid = 1'b0;
        check("midrst strobe1", 32'(cnt_en), 32'd1);
        @(negedge GCLK_Pad);                 // t+2: gap
        check("midrst gap", 32'(cnt_en), 32'd0);
        @(negedge GCLK_Pad);                 // t+3: strobe 2
        check("midrst strobe2", 32'(cnt_en), 32'd1);
        rst_Pad = 1'b1;
        @(negedge GCLK_Pad);
        rst_Pad = 1'b0;
        check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst busy",      32'(busy),      32'd0);
        check("midrst exp_val",   32'(exp_val),   32'd0);
        begin
            int en_seen, done_seen;
            en_seen   = 0;
            done_seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (cnt_en) en_seen++;
                if (done)   done_seen++;
                @(negedge GCLK_Pad);
            end
            check("midrst strobes after reset", 32'(en_seen),   32'd0);
            check("midrst done after reset",    32'(done_seen), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
